// File: rtl/seq_det_moore_param.sv
// Parametrised Moore serial sequence detector with runtime overlap mode,
// sample enable and a saturating, synchronously clearable match counter.
module seq_det_moore_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             a,
  input  logic             ovl,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] cnt
);

  localparam int SW = $clog2(N + 1);

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  // Pattern bit i (i = 0 is sent first) lives at PATTERN[N-1-i].
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j <= k + 1; j++) begin
      ok = (PATTERN[N - j] == b);
      for (int i = 0; i < j - 1; i++) begin
        ok = ok & (PATTERN[N - 1 - i] == PATTERN[N - k + j - 2 - i]);
      end
      best = ok ? j : best;
    end
    return best;
  endfunction

  function automatic int border_len();
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < N; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        ok = ok & (PATTERN[N - 1 - i] == PATTERN[j - 1 - i]);
      end
      best = ok ? j : best;
    end
    return best;
  endfunction

  function automatic logic [N*SW-1:0] build_tab(input logic b);
    logic [N*SW-1:0] t;
    t = '0;
    for (int k = 0; k < N; k++) begin
      t[k*SW +: SW] = SW'(kmp_next(k, b));
    end
    return t;
  endfunction

  localparam logic [N*SW-1:0] TAB0      = build_tab(1'b0);
  localparam logic [N*SW-1:0] TAB1      = build_tab(1'b1);
  localparam int              BORDER    = border_len();
  localparam logic [SW-1:0]   ST_FULL   = SW'(N);
  localparam logic [SW-1:0]   ST_BORDER = SW'(BORDER);

  logic [SW-1:0]    st_q, st_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sel_k, nxt_k;
  logic             hit;

  // Next-state, match decode and counter update.
  always_comb begin
    sel_k = st_q;
    nxt_k = '0;
    st_d  = st_q;
    cnt_d = cnt_q;
    // Leaving the full-match state restarts from the border or from scratch.
    if (st_q == ST_FULL) begin
      if (ovl) sel_k = ST_BORDER;
      else     sel_k = '0;
    end else begin
      sel_k = st_q;
    end
    for (int k = 0; k < N; k++) begin
      nxt_k = nxt_k | ((sel_k == SW'(k)) ? (a ? TAB1[k*SW +: SW] : TAB0[k*SW +: SW]) : '0);
    end
    if (en) st_d = nxt_k;
    else    st_d = st_q;
    hit = en && (nxt_k == ST_FULL);
    if (clr)                             cnt_d = '0;
    else if (hit && (cnt_q != '1))       cnt_d = cnt_q + CNT_W'(1);
    else                                 cnt_d = cnt_q;
    y_d = (st_d == ST_FULL);
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st_q  <= '0;
      y_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign y   = y_q;
  assign cnt = cnt_q;

endmodule
